// File: rtl/apc_lut_loader.sv
// apc_lut_loader
// Sequential loader for the 16-entry APC product LUT. On an accepted start it
// captures coefficient a and presents 16 consecutive writes: address k holds
// k*a for k=1..15 and address 0 holds 16*a. Multiples come from repeated
// addition into a P_W-bit accumulator (wrapping), so no multiplier is built.
//
// Optional feature macro: APC_LUT_LOADER_PARITY_EN
//   When defined, wr_data is P_W+1 bits with an even-parity bit on top
//   (the XOR of all wr_data bits is 0). When undefined, wr_data is P_W bits.
module apc_lut_loader #(
    parameter int A_W = 5,
    parameter int P_W = 9,
`ifdef APC_LUT_LOADER_PARITY_EN
    localparam int D_W = P_W + 1
`else
    localparam int D_W = P_W
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [A_W-1:0] a,
    output logic           busy,
    output logic           done,
    output logic           wr_en,
    output logic [3:0]     wr_addr,
    output logic [D_W-1:0] wr_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [A_W-1:0] coef, coef_n;
    logic [P_W-1:0] acc, acc_n;
    logic [P_W-1:0] sum;
    logic [4:0]     k, k_n;          // write index 1..16; 16 maps to address 0
    logic           busy_n, done_n, wr_en_n;
    logic [3:0]     wr_addr_n;
    logic [D_W-1:0] wr_data_n;

    // Build the stored word from a product value, adding parity when enabled.
    function automatic logic [D_W-1:0] pack_word(input logic [P_W-1:0] v);
`ifdef APC_LUT_LOADER_PARITY_EN
        return {^v, v};
`else
        return v;
`endif
    endfunction

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no
        // path through the case can leave one unassigned and infer a latch.
        state_n   = state;
        coef_n    = coef;
        acc_n     = acc;
        k_n       = k;
        done_n    = 1'b0;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        sum       = acc + P_W'(coef);

        case (state)
            S_IDLE: begin
                // start wins over abort here; abort only matters in LOAD
                if (start) begin
                    state_n   = S_LOAD;
                    coef_n    = a;
                    acc_n     = P_W'(a);
                    k_n       = 5'd1;
                    wr_en_n   = 1'b1;
                    wr_addr_n = 4'd1;
                    wr_data_n = pack_word(P_W'(a));
                end
            end
            S_LOAD: begin
                if (abort) begin
                    // already-presented writes stand; nothing further issued
                    state_n = S_IDLE;
                    acc_n   = '0;
                    k_n     = 5'd0;
                end else if (k == 5'd16) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else begin
                    acc_n     = sum;
                    k_n       = k + 5'd1;
                    wr_en_n   = 1'b1;
                    wr_addr_n = k_n[3:0];
                    wr_data_n = pack_word(sum);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                acc_n   = '0;
                k_n     = 5'd0;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state   <= S_IDLE;
            coef    <= '0;
            acc     <= '0;
            k       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_n;
            coef    <= coef_n;
            acc     <= acc_n;
            k       <= k_n;
            busy    <= busy_n;
            done    <= done_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
        end
    end

endmodule

// File: tb/tb_apc_lut_loader.sv
// tb_apc_lut_loader
// Self-checking bench for apc_lut_loader. Expected writes come from the
// arithmetic rule (address k mod 16 holds k*a mod 2^P_W), and a bench-side
// LUT image records every presented write for content checks after each load.
// Honours APC_LUT_LOADER_PARITY_EN the same way as the design.
module tb_apc_lut_loader;

    localparam int A_W = 5;
    localparam int P_W = 9;
`ifdef APC_LUT_LOADER_PARITY_EN
    localparam int D_W = P_W + 1;
`else
    localparam int D_W = P_W;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           abort;
    logic [A_W-1:0] a;
    logic           busy;
    logic           done;
    logic           wr_en;
    logic [3:0]     wr_addr;
    logic [D_W-1:0] wr_data;

    apc_lut_loader #(.A_W(A_W), .P_W(P_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .a       (a),
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Bench image of the LUT: contents and which entries were written.
    logic [D_W-1:0] lut [16];
    bit             lut_vld [16];
    int             wr_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference word for multiple k of coefficient av.
    function automatic logic [D_W-1:0] exp_word(input int k, input int av);
        logic [P_W-1:0] v;
        v = P_W'((k * av) % (1 << P_W));
`ifdef APC_LUT_LOADER_PARITY_EN
        return {^v, v};
`else
        return v;
`endif
    endfunction

    // Record the presented write (captured by the LUT at this edge), then
    // advance one clock and settle past the edge.
    task automatic tick();
        if (wr_en === 1'b1) begin
            lut[wr_addr]     = wr_data;
            lut_vld[wr_addr] = 1'b1;
            wr_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lut();
        for (int i = 0; i < 16; i++) lut_vld[i] = 1'b0;
        wr_cnt = 0;
    endtask

    // One load of coefficient av. abort_k>0 aborts while write k is presented.
    // hold_start keeps start high through the whole load; with_abort raises
    // abort together with the accepting start.
    task automatic run_load(input int av, input int abort_k, input bit hold_start,
                            input bit with_abort);
        clear_lut();
        a     = A_W'(av);
        start = 1'b1;
        abort = with_abort;
        tick();
        abort = 1'b0;
        start = hold_start;
        a     = A_W'($urandom);
        for (int k = 1; k <= 16; k++) begin
            check("wr_en", 32'(wr_en), 1);
            check("wr_addr", 32'(wr_addr), k % 16);
            check("wr_data", 32'(wr_data), 32'(exp_word(k, av)));
            check("busy_load", 32'(busy), 1);
            check("done_load", 32'(done), 0);
`ifdef APC_LUT_LOADER_PARITY_EN
            check("parity", 32'(^wr_data), 0);
`endif
            if (k == abort_k) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_wr_en", 32'(wr_en), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_done", 32'(done), 0);
                for (int c = 0; c < 3; c++) begin
                    tick();
                    check("post_abort_wr_en", 32'(wr_en), 0);
                    check("post_abort_done", 32'(done), 0);
                end
                check("abort_wr_cnt", 32'(wr_cnt), k);
                for (int i = 1; i < 16; i++) begin
                    check("abort_lut_vld", 32'(lut_vld[i]), (i <= k) ? 1 : 0);
                    if (i <= k) check("abort_lut", 32'(lut[i]), 32'(exp_word(i, av)));
                end
                check("abort_lut0_vld", 32'(lut_vld[0]), 0);
                return;
            end
            tick();
        end
        check("done_wr_en", 32'(wr_en), 0);
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 1);
        tick();
        check("idle_done", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_wr_en", 32'(wr_en), 0);
        check("wr_cnt", 32'(wr_cnt), 16);
        for (int i = 0; i < 16; i++) begin
            check("lut_vld", 32'(lut_vld[i]), 1);
            check("lut", 32'(lut[i]), 32'(exp_word((i == 0) ? 16 : i, av)));
        end
    endtask

    // Reset asserted while write 10 is presented: outputs clear at once.
    task automatic reset_mid_load(input int av);
        clear_lut();
        a     = A_W'(av);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        check("rst_pre_addr", 32'(wr_addr), 10);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("post_rst_wr_en", 32'(wr_en), 0);
            check("post_rst_busy", 32'(busy), 0);
        end
        check("rst_wr_cnt", 32'(wr_cnt), 9);
    endtask

    initial begin
        int av;
        int ak;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a     = '0;
        clear_lut();
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_wr_en", 32'(wr_en), 0);
        check("reset_wr_addr", 32'(wr_addr), 0);
        check("reset_wr_data", 32'(wr_data), 0);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", 32'(busy), 0);

        // abort alone in IDLE does nothing
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 0);
        check("idle_abort_wr_en", 32'(wr_en), 0);

        // directed loads
        run_load(5, 0, 1'b0, 1'b0);
        run_load(31, 0, 1'b0, 1'b0);
        run_load(0, 0, 1'b0, 1'b0);
        run_load(1, 0, 1'b0, 1'b0);
        run_load(7, 7, 1'b0, 1'b0);
        // start held for a whole load, then accepted again at E18
        run_load(9, 0, 1'b1, 1'b0);
        run_load(int'($urandom_range(0, 31)), 0, 1'b0, 1'b0);
        start = 1'b0;
        // start and abort together in IDLE: start wins
        run_load(int'($urandom_range(0, 31)), 0, 1'b0, 1'b1);

        // randomized loads with occasional aborts
        for (int n = 0; n < 8; n++) begin
            av = int'($urandom_range(0, 31));
            ak = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 15)) : 0;
            run_load(av, ak, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

        reset_mid_load(int'($urandom_range(1, 31)));

        // a normal load still works after the mid-load reset
        run_load(int'($urandom_range(0, 31)), 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
